ram_port_arbiter: RTL

- Shares the single data RAM port (separate read/write address, 1-cycle registered read) between master 0 (core load/store unit) and master 1 (debug/DMA loader).
- Sits between `core` and `ram` inside the CPU top level.
- Arbitrates per cycle (round-robin), supports a bounded lock for master-1 bursts, and routes read data back to its issuer.

---
 rtl/ram_arb_pkg.sv | 11 +
 rtl/ram_port_arbiter_rr_arb2.sv | 22 ++
 rtl/ram_port_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the data-RAM port arbiter.
package ram_arb_pkg;
  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int LOCK_MAX_DEF = 16;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_e;
  typedef enum logic [1:0] {ARB, LOCKED, COOL} arb_state_e;
  function automatic logic [1:0] onehot(master_e id);
    return (id == M1) ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin picker; force_en gives force_id priority when both request.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  input  master_e    force_id,
  input  logic       force_en,
  output logic [1:0] gnt
);
  master_e last, pick;
  always_comb begin
    pick = (req == 2'b11) ? (force_en ? force_id : ((last == M0) ? M1 : M0))
                          : (req[1] ? M1 : M0);
    gnt  = (req != 2'b00) ? onehot(pick) : 2'b00;
  end
  always_ff @(posedge clk)
    if (!rst_n) last <= M1;
    else if (accept) last <= pick;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one data RAM port between two masters with a bounded master-1 lock.
// Optional saturating performance counters when RAM_ARB_PERF_EN is defined.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              lock_abort
`ifdef RAM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_m0_stall,
  output logic [31:0]       perf_m1_stall,
  output logic [15:0]       perf_abort
`endif
);
  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  arb_state_e        state;
  logic [CW-1:0]     cnt;
  logic [1:0]        req, gnt;
  logic              any, sel, rv0, rv1;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  // m0 is masked out while master 1 owns the lock; nothing is granted in reset
  assign req = {m1_req & rst_n, m0_req & rst_n & (state != LOCKED)};
  rr_arb2 u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .accept   (any),
    .force_id (M0),
    .force_en (state == COOL),
    .gnt      (gnt)
  );
  always_comb begin
    any       = |gnt;
    sel       = gnt[1];
    m0_gnt    = gnt[0];
    m1_gnt    = gnt[1];
    sel_addr  = sel ? m1_addr : m0_addr;
    ram_raddr = any ? sel_addr : addr_q;
    ram_waddr = ram_raddr;
    ram_wdata = sel ? m1_wdata : m0_wdata;
    ram_we    = any & (sel ? m1_we : m0_we);
    m0_rvalid = rv0 & rst_n;
    m1_rvalid = rv1 & rst_n;
    m0_rdata  = m0_rvalid ? ram_rdata : '0;
    m1_rdata  = m1_rvalid ? ram_rdata : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state      <= ARB;
      cnt        <= '0;
      lock_abort <= 1'b0;
      rv0        <= 1'b0;
      rv1        <= 1'b0;
      addr_q     <= '0;
    end else begin
      rv0        <= gnt[0] & ~m0_we;
      rv1        <= gnt[1] & ~m1_we;
      lock_abort <= 1'b0;
      cnt        <= '0;
      if (any) addr_q <= sel_addr;
      if (state == ARB && gnt[1] && m1_lock) state <= LOCKED;
      else if (state == LOCKED) begin
        if (!m1_lock) state <= ARB;
        else if (cnt == CW'(LOCK_MAX - 1)) begin
          state      <= COOL;
          lock_abort <= 1'b1;
        end else cnt <= cnt + 1'b1;
      end else if (state == COOL) state <= ARB;
    end
`ifdef RAM_ARB_PERF_EN
  always_ff @(posedge clk)
    if (!rst_n) begin
      perf_m0_stall <= '0;
      perf_m1_stall <= '0;
      perf_abort    <= '0;
    end else begin
      if (m0_req && !m0_gnt && perf_m0_stall != '1) perf_m0_stall <= perf_m0_stall + 32'd1;
      if (m1_req && !m1_gnt && perf_m1_stall != '1) perf_m1_stall <= perf_m1_stall + 32'd1;
      if (lock_abort && perf_abort != '1) perf_abort <= perf_abort + 16'd1;
    end
`endif
endmodule
